// File: rtl/nbody_accel_accumulator_if.sv
// Stream bundle between the n-body array outputs, the per-body accumulator and its consumer.
// Master drives partial vectors, control pulses and out_ready; slave is the accumulator.
interface nbody_accel_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 20,
  parameter int IDX_W  = 2
) ();
  logic                  start;
  logic                  frame_done;
  logic                  a_valid;
  logic [IDX_W-1:0]      a_idx;
  logic                  a_neg;
  logic [3*DATA_W-1:0]   a_vec;
  logic                  b_valid;
  logic [IDX_W-1:0]      b_idx;
  logic                  b_neg;
  logic [3*DATA_W-1:0]   b_vec;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_W-1:0]      out_idx;
  logic [3*ACC_W-1:0]    out_vec;
  logic                  busy;
  logic                  overflow;
  logic                  idx_err;

  modport master (
    output start, frame_done,
    output a_valid, a_idx, a_neg, a_vec,
    output b_valid, b_idx, b_neg, b_vec,
    output out_ready,
    input  out_valid, out_idx, out_vec, busy, overflow, idx_err
  );

  modport slave (
    input  start, frame_done,
    input  a_valid, a_idx, a_neg, a_vec,
    input  b_valid, b_idx, b_neg, b_vec,
    input  out_ready,
    output out_valid, out_idx, out_vec, busy, overflow, idx_err
  );
endinterface

// File: rtl/nbody_accel_accumulator.sv
// Per-body 3D acceleration accumulator fed by two systolic lanes, drained in index order.
// Define ACCUM_SAT_EN to saturate overflowing components instead of wrapping them.
module nbody_accel_accumulator #(
  parameter int N_BODIES = 4,
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 20,
  parameter int IDX_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  nbody_accel_accumulator_if.slave bus
);

  // Two guard bits hold any acc + termA + termB without loss.
  localparam int SUM_W = ACC_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BODIES - 1);
`ifdef ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         out_idx_q, out_idx_d;
  logic                     overflow_q, overflow_d;
  logic                     idx_err_q, idx_err_d;
  logic signed [ACC_W-1:0]  acc_q [N_BODIES][3];
  logic signed [ACC_W-1:0]  acc_d [N_BODIES][3];
`ifdef ACCUM_SAT_EN
  logic                     sat_q [N_BODIES][3];
  logic                     sat_d [N_BODIES][3];
`endif
  logic signed [ACC_W-1:0]  term_a [3];
  logic signed [ACC_W-1:0]  term_b [3];
  logic signed [SUM_W-1:0]  sum_w  [N_BODIES][3];
  logic                     ovf_w  [N_BODIES][3];
  logic                     a_bad, b_bad;
  logic                     drain;

  function automatic logic signed [ACC_W-1:0] lane_term(input logic [DATA_W-1:0] v,
                                                        input logic neg);
    logic signed [ACC_W-1:0] e;
    e = {{(ACC_W-DATA_W){v[DATA_W-1]}}, v};
    return neg ? -e : e;
  endfunction

  function automatic logic signed [SUM_W-1:0] widen(input logic signed [ACC_W-1:0] v);
    return {{(SUM_W-ACC_W){v[ACC_W-1]}}, v};
  endfunction

  // Out-of-range indices only exist when the index space exceeds the body count.
  generate
    if ((1 << IDX_W) > N_BODIES) begin : g_idx_chk
      assign a_bad = ({1'b0, bus.a_idx} >= (IDX_W+1)'(N_BODIES));
      assign b_bad = ({1'b0, bus.b_idx} >= (IDX_W+1)'(N_BODIES));
    end else begin : g_idx_none
      assign a_bad = 1'b0;
      assign b_bad = 1'b0;
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      term_a[c] = lane_term(bus.a_vec[c*DATA_W +: DATA_W], bus.a_neg);
      term_b[c] = lane_term(bus.b_vec[c*DATA_W +: DATA_W], bus.b_neg);
    end
  end

  // Both lanes fold into one 3-operand sum so a shared target is judged on the final value.
  always_comb begin
    for (int i = 0; i < N_BODIES; i++) begin
      for (int c = 0; c < 3; c++) begin
        sum_w[i][c] = widen(acc_q[i][c])
                    + ((bus.a_valid && bus.a_idx == IDX_W'(i)) ? widen(term_a[c]) : '0)
                    + ((bus.b_valid && bus.b_idx == IDX_W'(i)) ? widen(term_b[c]) : '0);
        ovf_w[i][c] = (sum_w[i][c][SUM_W-1] != sum_w[i][c][ACC_W-1]) ||
                      (sum_w[i][c][SUM_W-2] != sum_w[i][c][ACC_W-1]);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    out_idx_d  = out_idx_q;
    overflow_d = overflow_q;
    idx_err_d  = idx_err_q;
    acc_d      = acc_q;
`ifdef ACCUM_SAT_EN
    sat_d      = sat_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_ACCUM;
          overflow_d = 1'b0;
          idx_err_d  = 1'b0;
          for (int i = 0; i < N_BODIES; i++) begin
            for (int c = 0; c < 3; c++) begin
              acc_d[i][c] = '0;
`ifdef ACCUM_SAT_EN
              sat_d[i][c] = 1'b0;
`endif
            end
          end
        end
      end
      ST_ACCUM: begin
        if (bus.frame_done) state_d = ST_DRAIN;
        if ((bus.a_valid && a_bad) || (bus.b_valid && b_bad)) idx_err_d = 1'b1;
        for (int i = 0; i < N_BODIES; i++) begin
          for (int c = 0; c < 3; c++) begin
            if (ovf_w[i][c]) overflow_d = 1'b1;
`ifdef ACCUM_SAT_EN
            // A clamped component is frozen until the next timestep.
            if (!sat_q[i][c]) begin
              if (ovf_w[i][c]) begin
                acc_d[i][c] = sum_w[i][c][SUM_W-1] ? ACC_MIN : ACC_MAX;
                sat_d[i][c] = 1'b1;
              end else begin
                acc_d[i][c] = sum_w[i][c][ACC_W-1:0];
              end
            end
`else
            acc_d[i][c] = sum_w[i][c][ACC_W-1:0];
`endif
          end
        end
      end
      ST_DRAIN: begin
        if (bus.out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            state_d   = ST_IDLE;
            out_idx_d = '0;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_idx_q  <= '0;
      overflow_q <= 1'b0;
      idx_err_q  <= 1'b0;
      for (int i = 0; i < N_BODIES; i++) begin
        for (int c = 0; c < 3; c++) begin
          acc_q[i][c] <= '0;
`ifdef ACCUM_SAT_EN
          sat_q[i][c] <= 1'b0;
`endif
        end
      end
    end else begin
      state_q    <= state_d;
      out_idx_q  <= out_idx_d;
      overflow_q <= overflow_d;
      idx_err_q  <= idx_err_d;
      acc_q      <= acc_d;
`ifdef ACCUM_SAT_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign drain         = (state_q == ST_DRAIN);
  assign bus.out_valid = drain;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.out_idx   = out_idx_q;
  assign bus.overflow  = overflow_q;
  assign bus.idx_err   = idx_err_q;
  assign bus.out_vec   = drain ? {acc_q[out_idx_q][2], acc_q[out_idx_q][1], acc_q[out_idx_q][0]}
                               : '0;

endmodule

// File: tb/tb_nbody_accel_accumulator.sv
// Directed bench for nbody_accel_accumulator: integer reference model checked every cycle,
// plus literal expectations for each scenario; a second N_BODIES=3 instance covers idx_err.
module tb_nbody_accel_accumulator;
  localparam int DW = 16;
  localparam int AW = 20;
  localparam int IW = 2;
  localparam longint AMAX = 524287;
  localparam longint AMIN = -524288;

  typedef struct {
    bit v;
    int idx;
    bit neg;
    int x;
    int y;
    int z;
  } lane_t;

  typedef enum {PH_IDLE, PH_ACCUM, PH_DRAIN} phase_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nbody_accel_accumulator_if #(.DATA_W(DW), .ACC_W(AW), .IDX_W(IW)) if4 ();
  nbody_accel_accumulator_if #(.DATA_W(DW), .ACC_W(AW), .IDX_W(IW)) if3 ();

  nbody_accel_accumulator #(.N_BODIES(4), .DATA_W(DW), .ACC_W(AW), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .bus(if4));
  nbody_accel_accumulator #(.N_BODIES(3), .DATA_W(DW), .ACC_W(AW), .IDX_W(IW)) dut3 (
    .clk(clk), .rst(rst), .bus(if3));

  int checks = 0;
  int errors = 0;

  phase_t phase = PH_IDLE;
  longint mdl [4][3];
  bit     msat [4][3];
  bit     m_ovf = 1'b0;
  int     exp_idx = 0;

  logic [IW-1:0]   beat_idx [$];
  logic [3*AW-1:0] beat_vec [$];

  function automatic lane_t L(input int idx, input bit neg, input int x, input int y, input int z);
    lane_t l;
    l.v = 1'b1; l.idx = idx; l.neg = neg; l.x = x; l.y = y; l.z = z;
    return l;
  endfunction

  function automatic lane_t NL();
    lane_t l;
    l.v = 1'b0; l.idx = 0; l.neg = 1'b0; l.x = 0; l.y = 0; l.z = 0;
    return l;
  endfunction

  function automatic logic [3*AW-1:0] pack3(input int x, input int y, input int z);
    return {z[AW-1:0], y[AW-1:0], x[AW-1:0]};
  endfunction

  function automatic longint wrap_acc(input longint t);
    longint u;
    u = (t - AMIN) % (AMAX - AMIN + 1);
    if (u < 0) u = u + (AMAX - AMIN + 1);
    return u + AMIN;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit sel3, input bit st, input bit fd, input lane_t a, input lane_t b);
    if (sel3) begin
      if3.start = st; if3.frame_done = fd;
      if3.a_valid = a.v; if3.a_idx = IW'(a.idx); if3.a_neg = a.neg;
      if3.a_vec = {DW'(a.z), DW'(a.y), DW'(a.x)};
      if3.b_valid = b.v; if3.b_idx = IW'(b.idx); if3.b_neg = b.neg;
      if3.b_vec = {DW'(b.z), DW'(b.y), DW'(b.x)};
    end else begin
      if4.start = st; if4.frame_done = fd;
      if4.a_valid = a.v; if4.a_idx = IW'(a.idx); if4.a_neg = a.neg;
      if4.a_vec = {DW'(a.z), DW'(a.y), DW'(a.x)};
      if4.b_valid = b.v; if4.b_idx = IW'(b.idx); if4.b_neg = b.neg;
      if4.b_vec = {DW'(b.z), DW'(b.y), DW'(b.x)};
    end
    tick();
    if3.start = 1'b0; if3.frame_done = 1'b0; if3.a_valid = 1'b0; if3.b_valid = 1'b0;
    if4.start = 1'b0; if4.frame_done = 1'b0; if4.a_valid = 1'b0; if4.b_valid = 1'b0;
  endtask

  task automatic drainOut();
    for (int n = 0; n < 20 && phase != PH_IDLE; n++) tick();
  endtask

  task automatic checkBeats(input string tag, input logic [3*AW-1:0] e0, input logic [3*AW-1:0] e1,
                            input logic [3*AW-1:0] e2, input logic [3*AW-1:0] e3);
    logic [3*AW-1:0] ev [4];
    ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
    checkOutput({tag, "_beats"}, 64'(beat_vec.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < beat_vec.size()) begin
        checkOutput($sformatf("%s_idx%0d", tag, i), 64'(beat_idx[i]), 64'(i));
        checkOutput($sformatf("%s_vec%0d", tag, i), 64'(beat_vec[i]), 64'(ev[i]));
      end
    end
  endtask

  // Reference model: plain integer sums per body, applied on each clock edge.
  task automatic modelLanes();
    longint add [4][3];
    longint t;
    for (int i = 0; i < 4; i++) for (int c = 0; c < 3; c++) add[i][c] = 0;
    for (int c = 0; c < 3; c++) begin
      if (if4.a_valid) begin
        t = longint'($signed(if4.a_vec[c*DW +: DW]));
        add[if4.a_idx][c] += if4.a_neg ? -t : t;
      end
      if (if4.b_valid) begin
        t = longint'($signed(if4.b_vec[c*DW +: DW]));
        add[if4.b_idx][c] += if4.b_neg ? -t : t;
      end
    end
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 3; c++) begin
        t = mdl[i][c] + add[i][c];
        if (t > AMAX || t < AMIN) m_ovf = 1'b1;
`ifdef ACCUM_SAT_EN
        if (!msat[i][c]) begin
          if (t > AMAX) begin mdl[i][c] = AMAX; msat[i][c] = 1'b1; end
          else if (t < AMIN) begin mdl[i][c] = AMIN; msat[i][c] = 1'b1; end
          else mdl[i][c] = t;
        end
`else
        mdl[i][c] = wrap_acc(t);
`endif
      end
    end
  endtask

  task automatic modelClear();
    for (int i = 0; i < 4; i++) for (int c = 0; c < 3; c++) begin
      mdl[i][c] = 0; msat[i][c] = 1'b0;
    end
    m_ovf = 1'b0;
  endtask

  initial begin
    modelClear();
    forever begin
      @(posedge clk);
      if (rst) begin
        phase = PH_IDLE; exp_idx = 0; modelClear();
      end else begin
        case (phase)
          PH_IDLE:  if (if4.start) begin phase = PH_ACCUM; modelClear(); end
          PH_ACCUM: begin
            modelLanes();
            if (if4.frame_done) begin phase = PH_DRAIN; exp_idx = 0; end
          end
          PH_DRAIN: if (if4.out_ready) begin
            exp_idx++;
            if (exp_idx == 4) begin phase = PH_IDLE; exp_idx = 0; end
          end
          default: phase = PH_IDLE;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (!rst && if4.out_valid && if4.out_ready) begin
        beat_idx.push_back(if4.out_idx);
        beat_vec.push_back(if4.out_vec);
      end
    end
  end

  // Every-cycle comparison of the 4-body instance against the model.
  initial begin
    logic [3*AW-1:0] ev;
    longint m;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("busy", 64'(if4.busy), 64'(phase != PH_IDLE));
        checkOutput("out_valid", 64'(if4.out_valid), 64'(phase == PH_DRAIN));
        checkOutput("overflow", 64'(if4.overflow), 64'(m_ovf));
        checkOutput("idx_err", 64'(if4.idx_err), 64'd0);
        if (phase == PH_DRAIN) begin
          for (int c = 0; c < 3; c++) begin
            m = mdl[exp_idx][c];
            ev[c*AW +: AW] = m[AW-1:0];
          end
          checkOutput("out_idx", 64'(if4.out_idx), 64'(exp_idx));
          checkOutput("out_vec", 64'(if4.out_vec), 64'(ev));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    if4.start = 0; if4.frame_done = 0; if4.a_valid = 0; if4.a_idx = 0; if4.a_neg = 0; if4.a_vec = 0;
    if4.b_valid = 0; if4.b_idx = 0; if4.b_neg = 0; if4.b_vec = 0; if4.out_ready = 1;
    if3.start = 0; if3.frame_done = 0; if3.a_valid = 0; if3.a_idx = 0; if3.a_neg = 0; if3.a_vec = 0;
    if3.b_valid = 0; if3.b_idx = 0; if3.b_neg = 0; if3.b_vec = 0; if3.out_ready = 1;
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_out_valid", 64'(if4.out_valid), 64'd0);
    checkOutput("rst_out_idx", 64'(if4.out_idx), 64'd0);
    checkOutput("rst_out_vec", 64'(if4.out_vec), 64'd0);
    checkOutput("rst_busy", 64'(if4.busy), 64'd0);
    checkOutput("rst_overflow", 64'(if4.overflow), 64'd0);
    checkOutput("rst_idx_err", 64'(if4.idx_err), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] scenario 1: two partials into body 0");
    beat_idx.delete(); beat_vec.delete();
    applyStimulus(0, 1, 0, NL(), NL());
    applyStimulus(0, 0, 0, L(0, 0, 100, -5, 0), NL());
    applyStimulus(0, 0, 0, L(0, 0, 20, 5, 7), NL());
    applyStimulus(0, 0, 1, NL(), NL());
    drainOut();
    checkBeats("t1", pack3(120, 0, 7), pack3(0, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0));
    checkOutput("t1_overflow", 64'(if4.overflow), 64'd0);

    $display("[TB] scenario 2: shared index with negate");
    beat_idx.delete(); beat_vec.delete();
    applyStimulus(0, 1, 0, NL(), NL());
    applyStimulus(0, 0, 0, L(2, 0, 10, 0, 0), L(2, 1, 10, 0, 0));
    applyStimulus(0, 0, 1, NL(), L(1, 1, 3, 4, 5));
    drainOut();
    checkBeats("t2", pack3(0, 0, 0), pack3(-3, -4, -5), pack3(0, 0, 0), pack3(0, 0, 0));

    $display("[TB] scenario 3: consumer back-pressure");
    beat_idx.delete(); beat_vec.delete();
    applyStimulus(0, 1, 0, NL(), NL());
    applyStimulus(0, 0, 0, L(1, 0, 1, 2, 3), NL());
    applyStimulus(0, 0, 1, NL(), NL());
    tick();
    if4.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("t3_hold_idx", 64'(if4.out_idx), 64'd1);
      checkOutput("t3_hold_vec", 64'(if4.out_vec), 64'(pack3(1, 2, 3)));
      tick();
    end
    if4.out_ready = 1'b1;
    tick();
    tick();
    checkOutput("t3_busy_before_last", 64'(if4.busy), 64'd1);
    tick();
    checkOutput("t3_busy_after_last", 64'(if4.busy), 64'd0);
    checkOutput("t3_valid_after_last", 64'(if4.out_valid), 64'd0);
    checkBeats("t3", pack3(0, 0, 0), pack3(1, 2, 3), pack3(0, 0, 0), pack3(0, 0, 0));

    $display("[TB] scenario 4: accumulator overflow");
    beat_idx.delete(); beat_vec.delete();
    applyStimulus(0, 1, 0, NL(), NL());
    for (int k = 0; k < 17; k++) applyStimulus(0, 0, 0, L(0, 0, 32767, 0, 0), NL());
    applyStimulus(0, 0, 1, NL(), NL());
    drainOut();
    checkOutput("t4_overflow", 64'(if4.overflow), 64'd1);
`ifdef ACCUM_SAT_EN
    checkBeats("t4", pack3(524287, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0));
`else
    checkBeats("t4", pack3(-491537, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0));
`endif

    $display("[TB] scenario 5: reset mid-drain");
    applyStimulus(0, 1, 0, NL(), NL());
    applyStimulus(0, 0, 0, L(2, 0, 5, 5, 5), NL());
    applyStimulus(0, 0, 1, NL(), NL());
    tick();
    tick();
    checkOutput("t5_idx_before_rst", 64'(if4.out_idx), 64'd2);
    rst = 1'b1;
    tick();
    checkOutput("t5_valid_after_rst", 64'(if4.out_valid), 64'd0);
    checkOutput("t5_busy_after_rst", 64'(if4.busy), 64'd0);
    rst = 1'b0;
    beat_idx.delete(); beat_vec.delete();
    applyStimulus(0, 1, 0, NL(), NL());
    applyStimulus(0, 0, 1, NL(), NL());
    drainOut();
    checkBeats("t5", pack3(0, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0), pack3(0, 0, 0));
    checkOutput("t5_overflow", 64'(if4.overflow), 64'd0);
    checkOutput("t5_idx_err", 64'(if4.idx_err), 64'd0);

    $display("[TB] scenario 6: out-of-range index on 3-body instance");
    applyStimulus(1, 1, 0, NL(), NL());
    applyStimulus(1, 0, 0, L(3, 0, 9, 9, 9), L(0, 0, 1, 2, 3));
    checkOutput("t6_idx_err_set", 64'(if3.idx_err), 64'd1);
    applyStimulus(1, 0, 1, NL(), NL());
    checkOutput("t6_valid", 64'(if3.out_valid), 64'd1);
    checkOutput("t6_idx0", 64'(if3.out_idx), 64'd0);
    checkOutput("t6_vec0", 64'(if3.out_vec), 64'(pack3(1, 2, 3)));
    tick();
    checkOutput("t6_idx1", 64'(if3.out_idx), 64'd1);
    checkOutput("t6_vec1", 64'(if3.out_vec), 64'(pack3(0, 0, 0)));
    tick();
    checkOutput("t6_idx2", 64'(if3.out_idx), 64'd2);
    checkOutput("t6_vec2", 64'(if3.out_vec), 64'(pack3(0, 0, 0)));
    tick();
    checkOutput("t6_busy_done", 64'(if3.busy), 64'd0);
    checkOutput("t6_overflow", 64'(if3.overflow), 64'd0);
    applyStimulus(1, 1, 0, NL(), NL());
    checkOutput("t6_idx_err_cleared", 64'(if3.idx_err), 64'd0);
    checkOutput("t6_busy_restart", 64'(if3.busy), 64'd1);
    applyStimulus(1, 0, 1, NL(), NL());
    for (int k = 0; k < 4; k++) tick();
    checkOutput("t6_busy_final", 64'(if3.busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
